// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared opcode/state types and constants for arith_unit_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arith_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : arith_iter_core
// Description : Iterative shift-add multiplier / restoring divider sharing
//               one WIDTH-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_iter_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic              r_busy;
    logic              r_mode;
    logic [CW-1:0]     r_cnt;
    logic [RW-1:0]     r_acc;
    logic [RW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [WIDTH-1:0]  r_quo;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_div;

    logic [RW-1:0]     w_acc_nxt;
    logic [WIDTH:0]    w_shift;
    logic [WIDTH:0]    w_diff;
    logic              w_fits;
    logic [WIDTH-1:0]  w_rem_nxt;
    logic [WIDTH-1:0]  w_quo_nxt;
    logic              w_last;

    always_comb begin
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
        // Restoring step: bring down the next dividend bit, keep the
        // difference only if it did not underflow.
        w_shift   = {r_rem, r_quo[WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_div};
        w_fits    = ~w_diff[WIDTH];
        w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
        w_last    = r_busy && (r_cnt == c_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_mode   <= MODE_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_mode   <= mode;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= RW'(a);
            r_mplier <= b;
            r_quo    <= a;
            r_rem    <= '0;
            r_div    <= b;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
            if (r_mode == MODE_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= {r_mcand[RW-2:0], 1'b0};
                r_mplier <= r_mplier >> 1;
            end else begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
            end
        end
    end

    // Results are the post-step values so the caller can latch them on the
    // same edge as the final iteration.
    assign busy      = r_busy;
    assign done      = w_last;
    assign product   = w_acc_nxt;
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

endmodule
`default_nettype wire

// File: rtl/arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit_seq
// Description : Valid/ready arithmetic unit: ADD/SUB single cycle, MUL and
//               DIV/MOD via the shared iterative core.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_unit_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    result,
    output logic             carry,
    output logic             div_zero,
    output logic             op_err
);

    state_e            r_state;
    state_e            w_state_nxt;

    logic [RW-1:0]     r_result;
    logic              r_carry;
    logic              r_div_zero;
    logic              r_op_err;
    logic              r_is_mod;

    op_e               w_op;
    logic              w_accept;
    logic              w_b_zero;
    logic              w_is_divmod;
    logic              w_core_start;
    logic              w_core_mode;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH-1:0]  w_sub;

    logic              w_core_busy;
    logic              w_core_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]  w_quotient;
    logic [WIDTH-1:0]  w_remainder;

    always_comb begin
        w_op         = op_e'(op);
        w_accept     = in_valid && in_ready;
        w_b_zero     = (b == '0);
        w_is_divmod  = (w_op == OP_DIV) || (w_op == OP_MOD);
        w_core_start = w_accept && ((w_op == OP_MUL) || (w_is_divmod && !w_b_zero));
        w_core_mode  = (w_op == OP_MUL) ? MODE_MUL : MODE_DIV;
        w_sum        = {1'b0, a} + {1'b0, b};
        w_sub        = a - b;
    end

    arith_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (w_core_start),
        .mode      (w_core_mode),
        .a         (a),
        .b         (b),
        .busy      (w_core_busy),
        .done      (w_core_done),
        .product   (w_product),
        .quotient  (w_quotient),
        .remainder (w_remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_state_nxt = MUL;
                    end else if (w_is_divmod && !w_b_zero) begin
                        w_state_nxt = DIV;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            // Leaving on !busy as well keeps the FSM from stranding if the
            // core was ever idle while we sit here.
            MUL, DIV: begin
                if (w_core_done || !w_core_busy) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_div_zero <= 1'b0;
            r_op_err   <= 1'b0;
            r_is_mod   <= 1'b0;
        end else if (w_accept) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_div_zero <= 1'b0;
            r_op_err   <= 1'b0;
            r_is_mod   <= (w_op == OP_MOD);
            case (w_op)
                OP_ADD: begin
                    r_result <= RW'(w_sum);
                    r_carry  <= w_sum[WIDTH];
                end
                OP_SUB: begin
                    r_result <= RW'(w_sub);
                    r_carry  <= (a < b);
                end
                OP_MUL: begin
                end
                OP_DIV: begin
                    if (w_b_zero) begin
                        r_result   <= RW'({WIDTH{1'b1}});
                        r_div_zero <= 1'b1;
                    end
                end
                OP_MOD: begin
                    if (w_b_zero) begin
                        r_result   <= RW'(a);
                        r_div_zero <= 1'b1;
                    end
                end
                default: r_op_err <= 1'b1;
            endcase
        end else if (w_core_done) begin
            if (r_state == MUL) begin
                r_result <= RW'(w_product);
            end else if (r_is_mod) begin
                r_result <= RW'(w_remainder);
            end else begin
                r_result <= RW'(w_quotient);
            end
        end
    end

    assign result   = r_result;
    assign carry    = r_carry;
    assign div_zero = r_div_zero;
    assign op_err   = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_unit_seq
// Description : Self-checking bench for arith_unit_seq (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit_seq;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          carry;
    logic          div_zero;
    logic          op_err;

    int n_tests = 0;
    int n_fail  = 0;

    arith_unit_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .div_zero  (div_zero),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [RW-1:0] res;
        logic          c;
        logic          dz;
        logic          err;
        int            lat;
        int            stall;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected behaviour straight from the arithmetic rules.
    task automatic model(input logic [2:0] o, input int xa, input int xb,
                         output logic [RW-1:0] r, output logic c, output logic dz,
                         output logic err, output int lat);
        int mask;
        mask = (1 << W) - 1;
        r = '0; c = 1'b0; dz = 1'b0; err = 1'b0; lat = 1;
        case (o)
            3'd0: begin r = RW'(xa + xb); c = (xa + xb) > mask; end
            3'd1: begin r = RW'((xa - xb) & mask); c = (xa < xb); end
            3'd2: begin r = RW'(xa * xb); lat = W + 1; end
            3'd3: if (xb == 0) begin r = RW'(mask); dz = 1'b1; end
                  else begin r = RW'(xa / xb); lat = W + 1; end
            3'd4: if (xb == 0) begin r = RW'(xa); dz = 1'b1; end
                  else begin r = RW'(xa % xb); lat = W + 1; end
            default: err = 1'b1;
        endcase
    endtask

    task automatic do_op(input string nm, input logic [2:0] o, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic [RW-1:0] er, input logic ec,
                         input logic edz, input logic eerr, input int elat, input int stall);
        int   lat;
        logic rdy_bad;
        check({nm, ".ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 1; rdy_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({nm, ".latency"},  32'(lat), 32'(elat));
        check({nm, ".busy_rdy"}, 32'(rdy_bad), 32'd0);
        check({nm, ".result"},   32'(result), 32'(er));
        check({nm, ".carry"},    32'(carry), 32'(ec));
        check({nm, ".div_zero"}, 32'(div_zero), 32'(edz));
        check({nm, ".op_err"},   32'(op_err), 32'(eerr));
        check({nm, ".done_rdy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check({nm, ".hold_val"}, 32'(out_valid), 32'd1);
            check({nm, ".hold_res"}, 32'(result), 32'(er));
            check({nm, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, ".post_val"}, 32'(out_valid), 32'd0);
        check({nm, ".post_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [RW-1:0] er;
        logic          ec, edz, eerr;
        int            elat;
        logic [2:0]    ro;
        logic [W-1:0]  ra, rb;
        logic          saw_valid;

        //           op    a        b      res     c     dz    err  lat st
        vecs[0]  = '{3'd0, 4'd14,   4'd12, 8'd26,  1'b1, 1'b0, 1'b0, 1, 0};
        vecs[1]  = '{3'd0, 4'd15,   4'd1,  8'd16,  1'b1, 1'b0, 1'b0, 1, 1};
        vecs[2]  = '{3'd1, 4'd12,   4'd14, 8'd14,  1'b1, 1'b0, 1'b0, 1, 0};
        vecs[3]  = '{3'd1, 4'd4,    4'd2,  8'd2,   1'b0, 1'b0, 1'b0, 1, 0};
        vecs[4]  = '{3'd2, 4'd15,   4'd15, 8'd225, 1'b0, 1'b0, 1'b0, 5, 0};
        vecs[5]  = '{3'd3, 4'd15,   4'd4,  8'd3,   1'b0, 1'b0, 1'b0, 5, 0};
        vecs[6]  = '{3'd4, 4'd15,   4'd4,  8'd3,   1'b0, 1'b0, 1'b0, 5, 0};
        vecs[7]  = '{3'd3, 4'd0,    4'd0,  8'd15,  1'b0, 1'b1, 1'b0, 1, 0};
        vecs[8]  = '{3'd4, 4'(17),  4'd0,  8'd1,   1'b0, 1'b1, 1'b0, 1, 0};
        vecs[9]  = '{3'd2, 4'd12,   4'd14, 8'd168, 1'b0, 1'b0, 1'b0, 5, 6};
        vecs[10] = '{3'd6, 4'd9,    4'd3,  8'd0,   1'b0, 1'b0, 1'b1, 1, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready",  32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result",    32'(result), 32'd0);
        check("reset.flags",     32'({carry, div_zero, op_err}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                  vecs[i].c, vecs[i].dz, vecs[i].err, vecs[i].lat, vecs[i].stall);
        end

        // Reset in cycle 2 of DIV 12/5 abandons the operation.
        in_valid = 1'b1; op = 3'd3; a = 4'd12; b = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready",  32'(in_ready), 32'd1);
        check("midrst.flags",     32'({carry, div_zero, op_err}), 32'd0);
        check("midrst.result",    32'(result), 32'd0);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst.no_partial", 32'(saw_valid), 32'd0);
        do_op("add_after_rst", 3'd0, 4'd4, 4'd2, 8'd6, 1'b0, 1'b0, 1'b0, 1, 0);

        for (int i = 0; i < 200; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(ro, int'(ra), int'(rb), er, ec, edz, eerr, elat);
            do_op($sformatf("rnd%0d_op%0d_%0d_%0d", i, ro, ra, rb), ro, ra, rb,
                  er, ec, edz, eerr, elat, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
- Parametrised, clocked arithmetic unit implementing ADD, SUB, MUL, DIV and MOD on two unsigned WIDTH-bit operands.
- Uses valid/ready handshakes on both the input and the output side.
- ADD/SUB complete in one cycle; MUL uses an iterative shift-add engine; DIV/MOD use an iterative restoring divider.
- Serves as the shared arithmetic datapath for operator exercises and for small datapaths in the design.

Parameters:
- WIDTH, 4: operand width in bits (legal range 2..32).
- RW, 2*WIDTH: result width. Derived; must not be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  unit can accept a request.
- op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5..7 illegal.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  RW  result, zero-extended.
- carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops.
- div_zero  out  1  DIV/MOD with b==0.
- op_err  out  1  illegal opcode.

Behaviour:
- Reset: one clock, synchronous, active-high. On reset: state=IDLE, in_ready=1, out_valid=0, result=0, carry=0, div_zero=0, op_err=0.
- States: IDLE, MUL, DIV, DONE.
- in_ready is 1 only in IDLE and never depends on out_ready.
- Request accept: in_valid && in_ready at a rising edge. a, b and op are captured in that cycle (cycle 0).
- IDLE, ADD/SUB/illegal op: result and flags registered at the accept edge; go to DONE, so out_valid=1 in cycle 1.
- IDLE, MUL: clear accumulator, go to MUL. After WIDTH iterations (one bit of b per cycle, LSB first), go to DONE; out_valid=1 in cycle WIDTH+1.
- IDLE, DIV/MOD with b!=0: go to DIV. Restoring division, one quotient bit per cycle, MSB first. After WIDTH cycles, go to DONE; out_valid=1 in cycle WIDTH+1.
- IDLE, DIV/MOD with b==0: go straight to DONE in cycle 1. div_zero=1. Result for DIV = zero-extended all-ones WIDTH bits; result for MOD = zero-extended a.
- DONE: result and flags held stable while out_valid && !out_ready. Go to IDLE on out_ready; out_valid drops in the next cycle.
- Throughput: minimum 2 cycles per ADD/SUB. There is no accept in the same cycle as the result handoff.
- Arithmetic rules:
  - ADD: result = a+b computed at WIDTH+1 bits; carry = bit WIDTH of the sum.
  - SUB: result = (a-b) mod 2^WIDTH, zero-extended; carry = (a<b).
  - MUL: full RW-bit product, no truncation.
  - DIV: quotient, zero-extended.
  - MOD: remainder, zero-extended.
- Illegal op: result=0, op_err=1, all other flags 0.
- Flags are exclusive per op; they are cleared on every accept.
- Reset mid-operation (MUL/DIV/DONE): the operation is abandoned; outputs return to reset values on the next edge with no partial output.
- Input changes while not in IDLE are ignored.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package arith_pkg holds:
  - op_e enum: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_MOD=4.
  - state_e enum: IDLE, MUL, DIV, DONE.
  - OP_W=3 constant.
- One sub-module, arith_iter_core (parameter WIDTH), holds the shared iterative engine:
  - Inputs: start, mode (mul/div), a, b.
  - Outputs: busy, done, product/quotient/remainder.
  - One shared WIDTH-cycle counter.
- The top level holds the FSM, handshakes, single-cycle ops and output registers.

Test Plan (WIDTH=4):
- ADD a=14,b=12 -> out_valid in cycle 1; result=26, carry=1. Also ADD a=15,b=1 -> result=16, carry=1.
- SUB a=12,b=14 -> result=14, carry(borrow)=1. Also SUB a=4,b=2 -> result=2, carry=0.
- MUL a=15,b=15 -> out_valid exactly 5 cycles after accept; result=225. in_ready=0 throughout.
- DIV a=15,b=4 -> result=3. MOD a=15,b=4 -> result=3. DIV a=0,b=0 -> cycle 1 result=15, div_zero=1. MOD a=17 (truncated to 1),b=0 -> result=1, div_zero=1.
- Backpressure: MUL 12*14 with out_ready=0 for 6 cycles -> result=168 held stable, in_ready=0. out_ready=1 -> out_valid=0 and in_ready=1 the next cycle. op=6 -> result=0, op_err=1.
- Reset asserted in cycle 2 of DIV 12/5 -> next cycle out_valid=0, in_ready=1, flags 0. A following ADD 4+2 -> result=6.
